// File: rtl/i2s_tx.sv
// I2S transmitter: serialises stereo samples onto bclk/lrclk/sdata.
// Ports: clk, reset (sync, active-high); sample_valid/sample_ready
//   handshake with sample_left/sample_right (WIDTH bits each);
//   bclk, lrclk, sdata I2S outputs; underrun one-clk pulse.
module i2s_tx #(
    parameter int WIDTH    = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_left,
    input  logic [WIDTH-1:0] sample_right,
    output logic             sample_ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [5:0] WIDTH_POS = 6'(WIDTH);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       bcnt_q, bcnt_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d;
    logic [WIDTH-1:0] buf_r_q, buf_r_d;
    logic [WIDTH-1:0] frm_l_q, frm_l_d;
    logic [WIDTH-1:0] frm_r_q, frm_r_d;
    logic             underrun_q, underrun_d;

    logic             div_wrap;
    logic             fall_evt;
    logic             frame_evt;
    logic             accept;
    logic [5:0]       slot_pos;
    logic [WIDTH-1:0] slot_word;

    always_comb begin
        div_wrap  = (div_q == DIV_LAST);
        fall_evt  = div_wrap && bclk_q;
        frame_evt = fall_evt && (bcnt_q == 6'd63);
        accept    = sample_valid && !buf_full_q;

        div_d      = div_wrap ? '0 : div_q + 1'b1;
        bclk_d     = div_wrap ? ~bclk_q : bclk_q;
        bcnt_d     = fall_evt ? bcnt_q + 6'd1 : bcnt_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        frm_l_d    = frm_l_q;
        frm_r_d    = frm_r_q;
        underrun_d = 1'b0;

        if (frame_evt) begin
            if (buf_full_q) begin
                frm_l_d    = buf_l_q;
                frm_r_d    = buf_r_q;
                buf_full_d = 1'b0;
            end else if (accept) begin
                // Bypass: the sample goes straight into this frame.
                frm_l_d = sample_left;
                frm_r_d = sample_right;
            end else begin
                frm_l_d    = '0;
                frm_r_d    = '0;
                underrun_d = 1'b1;
            end
        end else if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = sample_left;
            buf_r_d    = sample_right;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bcnt_q     <= 6'd63;
            buf_full_q <= 1'b0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            frm_l_q    <= '0;
            frm_r_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bcnt_q     <= bcnt_d;
            buf_full_q <= buf_full_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            frm_l_q    <= frm_l_d;
            frm_r_q    <= frm_r_d;
            underrun_q <= underrun_d;
        end
    end

    // sdata is decoded from registered bcnt and frame, so it only moves
    // when those move, i.e. on falling events. Slot position s carries
    // bit WIDTH-s; position 0 is the one-bclk I2S delay.
    always_comb begin
        slot_pos  = {1'b0, bcnt_q[4:0]};
        slot_word = bcnt_q[5] ? frm_r_q : frm_l_q;
        sdata     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (slot_pos == WIDTH_POS - 6'(i)) begin
                sdata = slot_word[i];
            end
        end
    end

    assign sample_ready = ~buf_full_q;
    assign bclk         = bclk_q;
    assign lrclk        = bcnt_q[5];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: default 16-bit/div-4 instance plus a
// 24-bit/div-1 instance, with hand-derived expected bit streams.
module tb_i2s_tx;

    logic        clk;
    logic        rst0, v0, rdy0, bclk0, lr0, sd0, ur0;
    logic [15:0] l0, r0;
    logic        rst1, v1, rdy1, bclk1, lr1, sd1, ur1;
    logic [23:0] l1, r1;

    int nvec = 0;
    int nerr = 0;
    int k    = 0;

    i2s_tx #(.WIDTH(16), .BCLK_DIV(4)) u0 (
        .clk(clk), .reset(rst0), .sample_valid(v0),
        .sample_left(l0), .sample_right(r0), .sample_ready(rdy0),
        .bclk(bclk0), .lrclk(lr0), .sdata(sd0), .underrun(ur0)
    );

    i2s_tx #(.WIDTH(24), .BCLK_DIV(1)) u1 (
        .clk(clk), .reset(rst1), .sample_valid(v1),
        .sample_left(l1), .sample_right(r1), .sample_ready(rdy1),
        .bclk(bclk1), .lrclk(lr1), .sdata(sd1), .underrun(ur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wait_k(input int t);
        while (k < t) tick();
    endtask

    // One bclk is 8 clk; the frame load edge is base, bit b is low
    // at base+8b+2 and high at base+8b+6.
    task automatic frame0(input int base, input int nb,
                          input logic [15:0] wl, input logic [15:0] wr);
        logic [15:0] w;
        int s;
        logic e;
        for (int b = 0; b < nb; b++) begin
            wait_k(base + 8 * b + 2);
            w = (b < 32) ? wl : wr;
            s = b % 32;
            e = 1'b0;
            if (s >= 1 && s <= 16) e = w[16 - s];
            chk($sformatf("sd0 f%0d b%0d", base, b), sd0, e);
            chk($sformatf("lr0 f%0d b%0d", base, b), lr0, b >= 32);
            chk($sformatf("bclk0lo f%0d b%0d", base, b), bclk0, 1'b0);
            wait_k(base + 8 * b + 6);
            chk($sformatf("bclk0hi f%0d b%0d", base, b), bclk0, 1'b1);
            chk($sformatf("sd0hold f%0d b%0d", base, b), sd0, e);
        end
    endtask

    initial begin
        logic [23:0] w1;
        int s1;
        logic e1;
        rst0 = 1'b1; v0 = 1'b0; l0 = '0; r0 = '0;
        rst1 = 1'b1; v1 = 1'b0; l1 = '0; r1 = '0;
        tick(); tick(); tick();

        chk("rst bclk0", bclk0, 1'b0);
        chk("rst lr0", lr0, 1'b1);
        chk("rst sd0", sd0, 1'b0);
        chk("rst ur0", ur0, 1'b0);
        chk("rst rdy0", rdy0, 1'b1);

        // Sample accepted before the first frame load.
        rst0 = 1'b0; v0 = 1'b1; l0 = 16'hA5C3; r0 = 16'h8001;
        k = 0;
        tick();
        chk("acc rdy0", rdy0, 1'b0);
        v0 = 1'b0; l0 = 16'hFFFF; r0 = 16'hFFFF;
        wait_k(3);
        chk("bclk0 k3", bclk0, 1'b0);
        wait_k(4);
        chk("bclk0 k4", bclk0, 1'b1);
        wait_k(8);
        chk("load0 ur0", ur0, 1'b0);
        chk("load0 lr0", lr0, 1'b0);
        chk("load0 rdy0", rdy0, 1'b1);
        frame0(8, 64, 16'hA5C3, 16'h8001);

        // Idle frame: zeros with one underrun pulse.
        wait_k(520);
        chk("idle ur0", ur0, 1'b1);
        wait_k(521);
        chk("idle ur0 end", ur0, 1'b0);
        frame0(520, 64, 16'h0000, 16'h0000);

        // Valid only in the frame-load cycle: bypass load.
        wait_k(1031);
        chk("byp rdy0 pre", rdy0, 1'b1);
        v0 = 1'b1; l0 = 16'h1234; r0 = 16'hFEDC;
        tick();
        chk("byp ur0", ur0, 1'b0);
        chk("byp rdy0", rdy0, 1'b1);
        // From here valid is held high continuously.
        l0 = 16'h1111; r0 = 16'h2222;
        tick();
        chk("s1 acc rdy0", rdy0, 1'b0);
        l0 = 16'h3333; r0 = 16'h4444;
        frame0(1032, 64, 16'h1234, 16'hFEDC);

        wait_k(1544);
        chk("f3 ur0", ur0, 1'b0);
        chk("f3 rdy0", rdy0, 1'b1);
        tick();
        chk("s2 acc rdy0", rdy0, 1'b0);
        l0 = 16'h5555; r0 = 16'h6666;
        frame0(1544, 64, 16'h1111, 16'h2222);

        wait_k(2056);
        chk("f4 ur0", ur0, 1'b0);
        chk("f4 rdy0", rdy0, 1'b1);
        tick();
        chk("s3 acc rdy0", rdy0, 1'b0);
        v0 = 1'b0;
        frame0(2056, 40, 16'h3333, 16'h4444);

        // Reset at bcnt=40 with the buffer holding 5555/6666.
        wait_k(2056 + 8 * 40 + 2);
        rst0 = 1'b1;
        tick();
        chk("mrst bclk0", bclk0, 1'b0);
        chk("mrst lr0", lr0, 1'b1);
        chk("mrst sd0", sd0, 1'b0);
        chk("mrst ur0", ur0, 1'b0);
        chk("mrst rdy0", rdy0, 1'b1);
        rst0 = 1'b0;
        k = 0;
        wait_k(8);
        chk("post ur0", ur0, 1'b1);
        chk("post rdy0", rdy0, 1'b1);
        wait_k(9);
        chk("post ur0 end", ur0, 1'b0);
        frame0(8, 64, 16'h0000, 16'h0000);

        // 24-bit instance, bclk period 2 clk.
        chk("rst bclk1", bclk1, 1'b0);
        chk("rst lr1", lr1, 1'b1);
        chk("rst sd1", sd1, 1'b0);
        chk("rst ur1", ur1, 1'b0);
        chk("rst rdy1", rdy1, 1'b1);
        rst1 = 1'b0; v1 = 1'b1; l1 = 24'h800001; r1 = 24'h7FFFFE;
        k = 0;
        tick();
        chk("w24 bclk1 k1", bclk1, 1'b1);
        chk("w24 rdy1", rdy1, 1'b0);
        v1 = 1'b0; l1 = 24'hFFFFFF; r1 = 24'h000000;
        wait_k(2);
        chk("w24 ur1", ur1, 1'b0);
        for (int b = 0; b < 64; b++) begin
            wait_k(2 * b + 2);
            w1 = (b < 32) ? 24'h800001 : 24'h7FFFFE;
            s1 = b % 32;
            e1 = 1'b0;
            if (s1 >= 1 && s1 <= 24) e1 = w1[24 - s1];
            chk($sformatf("sd1 b%0d", b), sd1, e1);
            chk($sformatf("lr1 b%0d", b), lr1, b >= 32);
            chk($sformatf("bclk1lo b%0d", b), bclk1, 1'b0);
            wait_k(2 * b + 3);
            chk($sformatf("bclk1hi b%0d", b), bclk1, 1'b1);
            chk($sformatf("sd1hold b%0d", b), sd1, e1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
